seq_divider: RTL and testbench

- Parametrised multi-cycle restoring divider for the datapath ALU.
- Replaces a single-cycle DIV path; produces quotient (written to LO half of Z) and remainder (written to HI half of Z).
- The control sequencer starts it with a start/done handshake and holds in the current T-step until done.
- Supports signed and unsigned modes, divide-by-zero and signed-overflow handling.

---
 rtl/divider_pkg.sv | 16 +
 rtl/seq_divider_if.sv | 27 ++
 rtl/div_step.sv | 32 +++
 rtl/seq_divider.sv | 147 ++++++++++++++
 tb/tb_seq_divider.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/divider_pkg.sv
// Shared definitions for the multi-cycle restoring divider: FSM encoding and
// the divide-by-zero quotient fill value.
package divider_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  // Fill bit replicated across the quotient on divide by zero (all ones).
  localparam logic DIV0_QUOTIENT = 1'b1;

endpackage

// File: rtl/seq_divider_if.sv
// Start/done handshake and operand/result bus between the control sequencer
// (master) and the divider (slave).
interface seq_divider_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, signed_mode, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, signed_mode, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift {rem, q} left, trial-subtract the divisor
// magnitude and keep the difference when it is non-negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] dmag,
  output logic [WIDTH-1:0] next_rem,
  output logic [WIDTH-1:0] next_q
);

  logic        [WIDTH:0]   shifted;
  logic signed [WIDTH+1:0] trial;
  logic                    unused_trial_bit;

  // Shifted remainder can reach 2^(WIDTH+1)-1, so the trial needs two guard bits.
  always_comb begin
    shifted = {rem, q[WIDTH-1]};
    trial   = signed'({1'b0, shifted}) - signed'({2'b00, dmag});
    if (!trial[WIDTH+1]) begin
      next_rem = trial[WIDTH-1:0];
    end else begin
      next_rem = shifted[WIDTH-1:0];
    end
    next_q = {q[WIDTH-2:0], ~trial[WIDTH+1]};
  end

  // A kept difference is always below the divisor, so this bit is zero.
  assign unused_trial_bit = trial[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned restoring divider with start/done handshake.
// Quotient feeds Z low, remainder feeds Z high.
module seq_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic          clock,
  input logic          clear,
  seq_divider_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               busy_r;
  logic               done_r;
  logic               dbz_r;
  logic [WIDTH-1:0]   quot_r;
  logic [WIDTH-1:0]   rem_out_r;

  logic [WIDTH-1:0]   a_lat;
  logic [WIDTH-1:0]   b_lat;
  logic               smode;
  logic               zero;
  logic               q_neg;
  logic               r_neg;
  logic [WIDTH-1:0]   dmag;
  logic [WIDTH-1:0]   q_reg;
  logic [WIDTH-1:0]   rem_reg;
  logic [WIDTH-1:0]   next_rem;
  logic [WIDTH-1:0]   next_q;
  logic [WIDTH-1:0]   q_res;
  logic [WIDTH-1:0]   r_res;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v,
                                              input logic c);
    return c ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic is_signed);
    return neg_if(v, is_signed & v[WIDTH-1]);
  endfunction

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_reg),
    .q        (q_reg),
    .dmag     (dmag),
    .next_rem (next_rem),
    .next_q   (next_q)
  );

  // Sign fix-up; the remainder follows the dividend and -0 stays 0.
  always_comb begin
    q_res = neg_if(q_reg, q_neg);
    r_res = neg_if(rem_reg, r_neg && (rem_reg != '0));
    if (zero) begin
      q_res = {WIDTH{DIV0_QUOTIENT}};
      r_res = a_lat;
    end
  end

  // Control FSM and registered outputs.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state     <= IDLE;
      cnt       <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      dbz_r     <= 1'b0;
      quot_r    <= '0;
      rem_out_r <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= PREP;
            busy_r <= 1'b1;
          end
        end
        PREP: begin
          dbz_r <= 1'b0;
          cnt   <= '0;
          // Divide by zero bypasses the iterations but keeps the FIX slot.
          state <= (b_lat == '0) ? FIX : ITER;
        end
        ITER: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          state     <= DONE;
          done_r    <= 1'b1;
          busy_r    <= 1'b0;
          dbz_r     <= zero;
          quot_r    <= q_res;
          rem_out_r <= r_res;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Datapath registers carry no reset; they are only read after being loaded.
  always_ff @(posedge clock) begin
    case (state)
      IDLE: begin
        if (bus.start) begin
          a_lat <= bus.dividend;
          b_lat <= bus.divisor;
          smode <= bus.signed_mode;
        end
      end
      PREP: begin
        zero    <= (b_lat == '0);
        q_neg   <= smode & (a_lat[WIDTH-1] ^ b_lat[WIDTH-1]);
        r_neg   <= smode & a_lat[WIDTH-1];
        dmag    <= magnitude(b_lat, smode);
        q_reg   <= magnitude(a_lat, smode);
        rem_reg <= '0;
      end
      ITER: begin
        rem_reg <= next_rem;
        q_reg   <= next_q;
      end
      default: begin
      end
    endcase
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quot_r;
  assign bus.remainder   = rem_out_r;
  assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider at WIDTH=32.
module tb_seq_divider;

  logic clock = 1'b0;
  logic clear = 1'b1;
  int   total = 0;
  int   passed = 0;

  seq_divider_if #(.WIDTH(32)) bus ();

  seq_divider #(.WIDTH(32)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      passed++;
    end
  endtask

  // Issue one operation, scramble the operand inputs afterwards, and wait for done.
  task automatic run_div(input logic sm, input logic [31:0] a,
                         input logic [31:0] b, output int lat);
    @(negedge clock);
    bus.start       = 1'b1;
    bus.signed_mode = sm;
    bus.dividend    = a;
    bus.divisor     = b;
    @(posedge clock);
    #1;
    bus.start       = 1'b0;
    bus.signed_mode = ~sm;
    bus.dividend    = ~a;
    bus.divisor     = 32'h5;
    check("busy_after_start", bus.busy, 1);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
    end
  endtask

  task automatic expect_result(input string tag, input int lat, input int exp_lat,
                               input logic [31:0] q, input logic [31:0] r,
                               input logic dbz);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_quotient"}, bus.quotient, q);
    check({tag, "_remainder"}, bus.remainder, r);
    check({tag, "_div_by_zero"}, bus.div_by_zero, dbz);
    check({tag, "_busy_in_done"}, bus.busy, 0);
    @(posedge clock);
    #1;
    check({tag, "_done_one_cycle"}, bus.done, 0);
  endtask

  initial begin
    int lat;
    int ndone;
    int first_lat;
    logic [31:0] q_cap;
    logic [31:0] r_cap;
    logic dbz_cap;

    bus.start       = 1'b0;
    bus.signed_mode = 1'b0;
    bus.dividend    = '0;
    bus.divisor     = '0;

    repeat (2) @(posedge clock);
    #1;
    check("reset_quotient", bus.quotient, 0);
    check("reset_remainder", bus.remainder, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_div_by_zero", bus.div_by_zero, 0);
    @(negedge clock);
    clear = 1'b0;

    run_div(1'b1, 32'hFFFFFFCD, 32'h00005635, lat);
    expect_result("s_m51_d22069", lat, 34, 32'h0, 32'hFFFFFFCD, 1'b0);

    run_div(1'b0, 32'd22069, 32'd17, lat);
    expect_result("u_22069_d17", lat, 34, 32'h512, 32'd3, 1'b0);

    run_div(1'b1, 32'hFFFFFFCD, 32'd17, lat);
    expect_result("s_m51_d17", lat, 34, 32'hFFFFFFFD, 32'd0, 1'b0);

    run_div(1'b1, 32'd7, 32'd0, lat);
    expect_result("s_7_d0", lat, 2, 32'hFFFFFFFF, 32'd7, 1'b1);
    check("dbz_held_idle", bus.div_by_zero, 1);
    check("quotient_held_idle", bus.quotient, 32'hFFFFFFFF);

    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, lat);
    expect_result("s_overflow", lat, 34, 32'h80000000, 32'd0, 1'b0);

    run_div(1'b0, 32'hFFFFFFFF, 32'd2, lat);
    expect_result("u_max_d2", lat, 34, 32'h7FFFFFFF, 32'd1, 1'b0);

    // Second start pulse while busy must be ignored.
    @(negedge clock);
    bus.start       = 1'b1;
    bus.signed_mode = 1'b0;
    bus.dividend    = 32'd22069;
    bus.divisor     = 32'd17;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    ndone = 0;
    first_lat = -1;
    q_cap = '0;
    r_cap = '0;
    dbz_cap = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        ndone++;
        if (first_lat < 0) begin
          first_lat = c;
          q_cap = bus.quotient;
          r_cap = bus.remainder;
          dbz_cap = bus.div_by_zero;
        end
      end
      if (c == 9) begin
        bus.start       = 1'b1;
        bus.signed_mode = 1'b1;
        bus.dividend    = 32'd7;
        bus.divisor     = 32'd0;
      end
    end
    check("restart_done_count", ndone, 1);
    check("restart_latency", first_lat, 34);
    check("restart_quotient", q_cap, 32'h512);
    check("restart_remainder", r_cap, 32'd3);
    check("restart_div_by_zero", dbz_cap, 0);

    // Asynchronous clear in the middle of the iterations.
    @(negedge clock);
    bus.start       = 1'b1;
    bus.signed_mode = 1'b1;
    bus.dividend    = 32'hFFFFFFCD;
    bus.divisor     = 32'd17;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clock);
    #2;
    clear = 1'b1;
    #1;
    check("clear_quotient", bus.quotient, 0);
    check("clear_remainder", bus.remainder, 0);
    check("clear_busy", bus.busy, 0);
    check("clear_done", bus.done, 0);
    @(negedge clock);
    clear = 1'b0;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clock);
      #1;
      if (bus.done === 1'b1) ndone++;
    end
    check("clear_no_done", ndone, 0);

    run_div(1'b0, 32'hFFFFFFFF, 32'd2, lat);
    expect_result("after_clear", lat, 34, 32'h7FFFFFFF, 32'd1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
